// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// Module   : shift_pkg
// Purpose  : Types shared by the shift register and the command sequencer
//            that drives it. funct_t is the function code on the
//            sequencer -> register interface.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    NA    = 2'b00,
    LOAD  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } funct_t;

endpackage

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// Module   : shift_sequencer
// Purpose  : Accepts "load-and-shift-N" commands over a valid/ready
//            handshake and replays each as one LOAD cycle followed by N
//            LEFT/RIGHT cycles on the shift-register interface, then a
//            one-cycle done pulse.
// Ports    : clk, rst            clock, asynchronous active-high reset
//            cmd_valid_i/ready_o command handshake (ready only in IDLE)
//            cmd_word_i          word to load
//            cmd_dir_i           0 = LEFT, 1 = RIGHT
//            cmd_count_i         shift cycles, clamped to WIDTH
//            cmd_fill_i          serial bit shifted in on each shift
//            abort_i             cancels a command in LOAD or SHIFT
//            funct_o/word_o/serial_o  drive the shift register
//            done_o              one-cycle completion pulse
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_word_i,
  input  logic             cmd_dir_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             cmd_fill_i,
  input  logic             abort_i,
  output funct_t           funct_o,
  output logic [WIDTH-1:0] word_o,
  output logic             serial_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q,  word_d;
  logic               dir_q,   dir_d;
  logic               fill_q,  fill_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // State and latched command fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // Abort is deliberately not looked at here: a command arriving
        // together with abort is still taken.
        if (cmd_valid_i) begin
          word_d  = cmd_word_i;
          dir_d   = cmd_dir_i;
          fill_d  = cmd_fill_i;
          cnt_d   = (cmd_count_i > MAX_CNT) ? MAX_CNT : cmd_count_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          // cnt_q holds the shifts still to perform including this one
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs, decoded from registered state only
  always_comb begin
    cmd_ready_o = 1'b0;
    funct_o     = NA;
    serial_o    = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE:  cmd_ready_o = 1'b1;
      S_LOAD:  funct_o     = LOAD;
      S_SHIFT: begin
        funct_o  = dir_q ? RIGHT : LEFT;
        serial_o = fill_q;
      end
      S_DONE:  done_o      = 1'b1;
      default: cmd_ready_o = 1'b0;
    endcase
  end

  assign word_o = word_q;

endmodule

`default_nettype wire
